mydataset_lane_acc_requant: RTL
===============================

// Module: mydataset_lane_acc_requant
// PURPOSE
//  Consumes the signed 22-bit product stream from the 16s x 6s conv multiplier.
//  Accumulates one kernel window (group delimited by in_last) and adds a per-channel bias.
//  Rounds, arithmetic-shifts, saturates and optionally applies ReLU to give a 16-bit activation.
//  Sits between the lane-CNN conv multiplier and the feature-map line buffer; in_ready drives the multiplier ce.
// PARAMETERS
//  IN_W      22  product width (signed)
//  ACC_W     32  accumulator width (signed), ACC_W > IN_W
//  OUT_W     16  activation width (signed)
//  SHIFT     2   requant right shift, 0..ACC_W-OUT_W
//  MAX_TAPS  25  max beats per group (5x5 kernel)
// PORTS
//  clk        in   1      clock, all regs rise-edge
//  reset      in   1      async active-low reset (0 = reset)
//  in_valid   in   1      product beat valid
//  in_ready   out  1      beat accepted when in_valid & in_ready
//  in_data    in   IN_W   signed product
//  in_last    in   1      final beat of group
//  bias       in   OUT_W  signed bias, sampled with the accepted last beat
//  relu_en    in   1      1 = clamp negatives to 0, sampled with last beat
//  out_valid  out  1      activation valid
//  out_ready  in   1      downstream accept
//  out_data   out  OUT_W  signed activation
//  err_ovf    out  1      sticky: accumulator saturated
//  err_len    out  1      sticky: group exceeded MAX_TAPS beats
//  err_clr    in   1      sync clear of both sticky flags (set wins if same cycle)
// BEHAVIOUR
//  Reset: acc=0, tap_cnt=0, state=IDLE, fin_valid=0, out_valid=0, out_data=0, err_*=0.
//  Reset mid-group discards the partial sum; no output is produced for that group.
//  FSM: IDLE (no partial sum) -> ACCUM on accepted non-last beat; ACCUM -> IDLE on accepted last.
//    An accepted last in IDLE is a 1-beat group.
//  Accumulate: first beat acc = sext(in_data), later acc = acc + sext(in_data), saturating to ACC_W.
//    Saturation sets err_ovf.
//  tap_cnt counts beats in the group. Beat number MAX_TAPS+1 sets err_len.
//    The group still completes at in_last.
//  Stage A (fin): on an accepted last beat, fin_sum = sat_ACC(acc_next + sext(bias)).
//    Overflow here also sets err_ovf. fin_valid=1, relu_en is latched.
//  Stage B (out):
//    r = (fin_sum + (SHIFT ? 1<<(SHIFT-1) : 0)) >>> SHIFT, saturating add.
//    Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    If relu_en and r<0, r=0.
//    Register r into out_data and set out_valid.
//  Advance: advB = !out_valid | out_ready; B loads when fin_valid & advB.
//    fin clears on that load unless a new last beat loads it the same cycle.
//  in_ready = !fin_valid | advB. Combinational from out_ready; no other comb in->out paths.
//  Latency: last beat accepted at edge k -> fin_valid after k -> out_valid after k+1 (unstalled).
//  Throughput: 1 beat/cycle; back-to-back 1-beat groups sustain 1 result/cycle.
//  out_data/out_valid hold stable while out_valid & !out_ready.
//  in_data is ignored when !in_valid. in_last/bias/relu_en are only meaningful on accepted beats.
// STRUCTURE
//  Package mydataset_lane_pkg:
//    IN_W/ACC_W/OUT_W localparams
//    sat_add function
//    FSM state typedef {IDLE, ACCUM}
//  Sub-module mydataset_lane_requant: combinational round/shift/saturate/ReLU, params ACC_W/OUT_W/SHIFT.
//  Top holds the FSM, tap counter, accumulator, fin and out registers, and the sticky flags.
// TESTING
//  1. Basic group: beats 100,-50,30(last), bias=8, relu_en=0, SHIFT=2 -> out_data=22, one out_valid pulse 2 cycles after last.
//  2. Negative / ReLU: beat -400(last), bias=0, SHIFT=2 -> -100 with relu_en=0; 0 with relu_en=1.
//  3. Output saturation: beat 2097151(last) -> 32767; beat -2097152(last) -> -32768; err_ovf stays 0.
//  4. Accumulator saturation: ACC_W=24, five beats of 2097151 -> acc clamps to 8388607, err_ovf=1.
//     err_clr pulse then clears it.
//  5. Length error: 26 beats of 1, last on beat 26 -> err_len=1, out_data=(26+bias+2)>>>2.
//  6. Backpressure: out_ready=0, send three 1-beat groups 4,8,12 (bias 0).
//     in_ready drops after two results are buffered.
//     Release out_ready -> outputs 1,2,3 in order, none lost or duplicated.
//  7. Reset mid-group: 2 beats of 1000, assert reset, then one beat 4(last), bias=0 -> out_data=1 (partial sum discarded).

Source files
------------

// File: rtl/mydataset_lane_pkg.sv
//------------------------------------------------------------------------------
// Module : mydataset_lane_pkg
// Brief  : Shared widths, FSM state type and saturating helpers for the
//          lane-CNN accumulate/requantise stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mydataset_lane_pkg;

  localparam int IN_W  = 22;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Signed add clamped to w bits; ovf reports that clamping happened.
  function automatic logic signed [63:0] sat_add(input  logic signed [63:0] a,
                                                 input  logic signed [63:0] b,
                                                 input  int                 w,
                                                 output logic               ovf);
    logic signed [63:0] s;
    logic signed [63:0] c;
    s   = a + b;
    c   = sat_clamp(s, w);
    ovf = (c != s);
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mydataset_lane_requant.sv
//------------------------------------------------------------------------------
// Module : mydataset_lane_requant
// Brief  : Combinational round-half-up, arithmetic shift, output saturation
//          and optional ReLU from accumulator width to activation width.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mydataset_lane_requant #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 2
) (
  input  logic signed [ACC_W-1:0] fin_sum,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] r
);
  import mydataset_lane_pkg::*;

  // Half an output LSB; zero when no shift is applied.
  localparam logic signed [63:0] RND =
    (SHIFT == 0) ? 64'sd0 : (64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0));

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  // Round (saturating in ACC_W), shift, clamp to OUT_W, then ReLU.
  always_comb begin
    rounded = ACC_W'(sat_clamp(64'(fin_sum) + RND, ACC_W));
    shifted = rounded >>> SHIFT;
    r       = OUT_W'(sat_clamp(64'(shifted), OUT_W));
    if (relu_en && r[OUT_W-1]) begin
      r = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mydataset_lane_acc_requant.sv
//------------------------------------------------------------------------------
// Module : mydataset_lane_acc_requant
// Brief  : Accumulates one kernel window of signed products, adds a
//          per-channel bias and requantises to a 16-bit activation through a
//          two-register (fin, out) elastic pipeline.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mydataset_lane_acc_requant #(
  parameter int IN_W     = mydataset_lane_pkg::IN_W,
  parameter int ACC_W    = mydataset_lane_pkg::ACC_W,
  parameter int OUT_W    = mydataset_lane_pkg::OUT_W,
  parameter int SHIFT    = 2,
  parameter int MAX_TAPS = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  input  logic signed [OUT_W-1:0] bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    err_ovf,
  output logic                    err_len,
  input  logic                    err_clr
);
  import mydataset_lane_pkg::*;

  // Counter saturates at MAX_TAPS+1 so an over-long group cannot wrap.
  localparam int             CW      = $clog2(MAX_TAPS + 2);
  localparam logic [CW-1:0]  TAP_LIM = CW'(MAX_TAPS + 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]           tap_cnt_q, tap_cnt_d;
  logic                    fin_valid_q, fin_valid_d;
  logic signed [ACC_W-1:0] fin_sum_q, fin_sum_d;
  logic                    fin_relu_q, fin_relu_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    err_ovf_q, err_ovf_d;
  logic                    err_len_q, err_len_d;

  logic                    adv_b;
  logic                    accept;
  logic                    load_b;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] fin_next;
  logic                    ovf_acc;
  logic                    ovf_fin;
  logic [CW-1:0]           cnt_next;
  logic signed [OUT_W-1:0] req_data;

  // Handshake: the out stage advances when empty or drained; fin can take a
  // new beat whenever it is empty or is moving into the out stage.
  always_comb begin
    adv_b    = !out_valid_q || out_ready;
    in_ready = !fin_valid_q || adv_b;
    accept   = in_valid && in_ready;
    load_b   = fin_valid_q && adv_b;
  end

  // Datapath for the current beat: running sum, biased sum and beat count.
  always_comb begin
    acc_base = (state_q == IDLE) ? '0 : acc_q;
    acc_next = ACC_W'(sat_add(64'(acc_base), 64'(in_data), ACC_W, ovf_acc));
    fin_next = ACC_W'(sat_add(64'(acc_next), 64'(bias), ACC_W, ovf_fin));
    if (state_q == IDLE) begin
      cnt_next = CW'(1);
    end else if (tap_cnt_q == TAP_LIM) begin
      cnt_next = tap_cnt_q;
    end else begin
      cnt_next = tap_cnt_q + CW'(1);
    end
  end

  // Next state for the group FSM, the fin and out stages and sticky flags.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    fin_valid_d = fin_valid_q;
    fin_sum_d   = fin_sum_q;
    fin_relu_d  = fin_relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (load_b) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data;
      fin_valid_d = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_last) begin
        state_d     = IDLE;
        acc_d       = '0;
        tap_cnt_d   = '0;
        fin_valid_d = 1'b1;
        fin_sum_d   = fin_next;
        fin_relu_d  = relu_en;
      end else begin
        state_d   = ACCUM;
        acc_d     = acc_next;
        tap_cnt_d = cnt_next;
      end
    end

    err_ovf_d = (err_ovf_q && !err_clr) ||
                (accept && (ovf_acc || (in_last && ovf_fin)));
    err_len_d = (err_len_q && !err_clr) ||
                (accept && (cnt_next > CW'(MAX_TAPS)));
  end

  mydataset_lane_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .fin_sum (fin_sum_q),
    .relu_en (fin_relu_q),
    .r       (req_data)
  );

  // State registers; an asserted reset drops any partial group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      fin_valid_q <= 1'b0;
      fin_sum_q   <= '0;
      fin_relu_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      fin_valid_q <= fin_valid_d;
      fin_sum_q   <= fin_sum_d;
      fin_relu_q  <= fin_relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_ovf_q   <= err_ovf_d;
      err_len_q   <= err_len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_ovf   = err_ovf_q;
  assign err_len   = err_len_q;

endmodule

`default_nettype wire
